path_replayer: RTL

Downstream consumer of the direction stack in the maze-solver datapath. Once the solver finishes, `path_replayer` drains every stored move from the stack, which yields moves last-first. It then replays them in forward order, first move first, over a valid/ready stream. Each beat carries the move and the maze coordinate reached after it, so the result/display stage sees the solved path from start to goal.

---
 rtl/path_replayer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/path_replayer.sv
// Drains the direction stack into a local path buffer, then replays the moves
// first-to-last over a valid/ready stream with the coordinate reached after each move.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; final position of the last run is held
// POP     | empty/overflow check, otherwise issue one stack pop
// CAPTURE | popped move lands in the buffer at cnt
// EMIT    | offer buf[rd] with the next position; step on handshake
// DONE    | one-cycle done pulse
module path_replayer #(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 256,
    parameter int COORD_W = 4,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               stk_empty,
    input  logic [WIDTH-1:0]   stk_dout,
    output logic               stk_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_move,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic               err_q, err_d;
    logic               mem_we;
    logic [CW-1:0]      cnt_m1;
    logic [WIDTH-1:0]   path_mem_q [DEPTH];

    // buffer holds moves in pop order, so index 0 is the last move of the path
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            path_mem_q[cnt_q[AW-1:0]] <= stk_dout;
        end
    end

    assign cnt_m1   = cnt_q - CW'(1);
    assign out_move = (state_q == S_EMIT) ? path_mem_q[rd_q] : '0;
    assign err      = err_q;

    always_comb begin
        out_x = pos_x_q;
        out_y = pos_y_q;
        case (out_move)
            2'b00:   out_x = pos_x_q + COORD_W'(1);
            2'b01:   out_y = pos_y_q - COORD_W'(1);
            2'b10:   out_x = pos_x_q - COORD_W'(1);
            default: out_y = pos_y_q + COORD_W'(1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        stk_pop   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    pos_x_d = COORD_W'(START_X);
                    pos_y_d = COORD_W'(START_Y);
                    err_d   = 1'b0;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (stk_empty) begin
                    rd_d    = cnt_m1[AW-1:0];
                    state_d = (cnt_q != '0) ? S_EMIT : S_DONE;
                end else if (cnt_q == CW'(DEPTH)) begin
                    err_d   = 1'b1;
                    rd_d    = cnt_m1[AW-1:0];
                    state_d = S_EMIT;
                end else begin
                    stk_pop = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                mem_we  = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                state_d = S_POP;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_last  = (rd_q == '0);
                if (out_ready) begin
                    pos_x_d = out_x;
                    pos_y_d = out_y;
                    rd_d    = rd_q - AW'(1);
                    if (out_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            pos_x_q <= COORD_W'(START_X);
            pos_y_q <= COORD_W'(START_Y);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            err_q   <= err_d;
        end
    end

endmodule
